prompt_string_decoder: RTL

PROMPT_STRING_DECODER -- requirements
Module: prompt_string_decoder

---
 rtl/prompt_pkg.sv | 37 +++
 rtl/gap_timer.sv | 30 +++
 rtl/prompt_string_decoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/prompt_pkg.sv
// prompt_pkg: shared constants, prompt codes and decoder state encoding
// for prompt_string_decoder. The GAP state only exists when the
// PROMPT_GAP_EN macro is defined.
package prompt_pkg;

    localparam int STRING_W   = 64;
    localparam int BITCNT_W   = 7;              // holds 0..STRING_W
    localparam int ONES_W     = 3;              // holds 0..MAX_ONES
    localparam int COUNT_W    = 6;              // holds 0..MAX_TOKENS
    localparam int MAX_ONES   = 4;
    localparam int MAX_TOKENS = STRING_W / 2;   // shortest token is "10"

    typedef enum logic [2:0] {
        PROMPT_NONE   = 3'd0,
        PROMPT_TOGGLE = 3'd1,
        PROMPT_PUSH   = 3'd2,
        PROMPT_MIC    = 3'd3,
        PROMPT_MOUSE  = 3'd4
    } prompt_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SKIP  = 3'd1,
        ST_COUNT = 3'd2,
        ST_EMIT  = 3'd3,
`ifdef PROMPT_GAP_EN
        ST_GAP   = 3'd4,
`endif
        ST_DONE  = 3'd5
    } state_t;

    // Token counter increment that stops at the most tokens a string can hold.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value >= COUNT_W'(MAX_TOKENS)) ? value : value + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/gap_timer.sv
// gap_timer: loadable down-counter used to hold the decoder idle between
// prompts. expired pulses during the last cycle of the loaded interval.
// Only instantiated when PROMPT_GAP_EN is defined.
module gap_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] remaining_q;

    // Reload on request, otherwise count down to zero and stay there.
    always_ff @(posedge clock) begin
        if (!reset) begin
            remaining_q <= '0;
        end else if (load) begin
            remaining_q <= load_value;
        end else if (remaining_q != '0) begin
            remaining_q <= remaining_q - WIDTH'(1);
        end
    end

    // Last cycle of the interval: the count is about to reach zero.
    assign expired = (remaining_q == WIDTH'(1));

endmodule

// File: rtl/prompt_string_decoder.sv
// prompt_string_decoder: walks a 64-bit prompt string MSB-first, skips the
// leading zeros, then decodes unary tokens (k ones + one zero, k = 1..4)
// into prompt codes handed out over a valid/ready handshake.
// The string input is called prompt_string because "string" is a
// SystemVerilog keyword.
// Optional feature: define PROMPT_GAP_EN to insert GAP_CYCLES idle cycles
// after every accepted prompt.
module prompt_string_decoder
    import prompt_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [STRING_W-1:0] prompt_string,
    output logic [2:0]          prompt,
    output logic                prompt_valid,
    input  logic                prompt_ready,
    output logic                done,
    output logic                error,
    output logic [COUNT_W-1:0]  count,
    output logic                busy
);

    state_t                state_q,  state_d;
    logic [STRING_W-1:0]   shreg_q,  shreg_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [ONES_W-1:0]     ones_q,   ones_d;
    logic [COUNT_W-1:0]    count_q,  count_d;
    logic                  error_q,  error_d;
    prompt_t               code_q,   code_d;

`ifdef PROMPT_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    logic gap_load;
    logic gap_expired;

    gap_timer #(
        .WIDTH      (GAP_W)
    ) u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_W'(GAP_CYCLES)),
        .expired    (gap_expired)
    );
`endif

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of every other register.
        if (!reset) begin
            state_q  <= ST_IDLE;
            // NOTE: the shift register is ordinary state, not a memory
            // array, so it is cleared along with everything else.
            shreg_q  <= '0;
            bitcnt_q <= '0;
            ones_q   <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            code_q   <= PROMPT_NONE;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            ones_q   <= ones_d;
            count_q  <= count_d;
            error_q  <= error_d;
            code_q   <= code_d;
        end
    end

    // Next-state and datapath update: one string bit consumed per cycle.
    always_comb begin
        // NOTE: every signal assigned here gets a hold default first, so no
        // branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        ones_d   = ones_q;
        count_d  = count_q;
        error_d  = error_q;
        code_d   = code_q;
`ifdef PROMPT_GAP_EN
        gap_load = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d  = prompt_string;
                    bitcnt_d = '0;
                    ones_d   = '0;
                    count_d  = '0;
                    error_d  = 1'b0;
                    state_d  = ST_SKIP;
                end
            end

            ST_SKIP: begin
                if (shreg_q == '0) begin
                    state_d = ST_DONE;
                end else if (shreg_q[STRING_W-1]) begin
                    // First token bit reached; COUNT consumes it.
                    state_d = ST_COUNT;
                end else begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q + BITCNT_W'(1);
                end
            end

            ST_COUNT: begin
                if (ones_q == '0 && shreg_q == '0) begin
                    // Only trailing zeros left between tokens: clean end.
                    state_d = ST_DONE;
                end else if (bitcnt_q == BITCNT_W'(STRING_W)) begin
                    // String ran out inside a token (no terminating zero).
                    state_d = ST_DONE;
                    error_d = 1'b1;
                end else begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    if (shreg_q[STRING_W-1]) begin
                        if (ones_q == ONES_W'(MAX_ONES)) begin
                            // A fifth one: no such token.
                            state_d = ST_DONE;
                            error_d = 1'b1;
                        end else begin
                            ones_d = ones_q + ONES_W'(1);
                        end
                    end else if (ones_q == '0) begin
                        // A zero with no ones before it, more ones still to come.
                        state_d = ST_DONE;
                        error_d = 1'b1;
                    end else begin
                        code_d  = prompt_t'(ones_q);
                        state_d = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                if (prompt_ready) begin
                    count_d = sat_inc(count_q);
                    ones_d  = '0;
`ifdef PROMPT_GAP_EN
                    if (GAP_CYCLES > 0) begin
                        gap_load = 1'b1;
                        state_d  = ST_GAP;
                    end else begin
                        state_d  = ST_COUNT;
                    end
`else
                    state_d = ST_COUNT;
`endif
                end
            end

`ifdef PROMPT_GAP_EN
            ST_GAP: begin
                if (gap_expired) begin
                    state_d = ST_COUNT;
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; prompt is forced to zero outside EMIT.
    always_comb begin
        prompt_valid = (state_q == ST_EMIT);
        prompt       = prompt_valid ? code_q : PROMPT_NONE;
        done         = (state_q == ST_DONE);
        busy         = (state_q != ST_IDLE);
        error        = error_q;
        count        = count_q;
    end

endmodule
